// File: rtl/serdes_pkg.sv
// Shared definitions for the piso/sipo serial link: FSM state codes, bit-order keyword, clog2.
package serdes_pkg;

  localparam logic ST_HUNT  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    HUNT  = ST_HUNT,
    SHIFT = ST_SHIFT
  } rx_state_e;

  // Keyword that enables a string-valued option (bit order, sync requirement).
  localparam string BIT_ORDER_TRUE = "TRUE";

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: rebuilds DATA_WIDTH-bit words from strobed bits; word valid 1 cycle after last strobe.
// Strobes are never stalled; a word completing while the single output entry is held is dropped and flags sticky overrun.
module sipo_rx
  import serdes_pkg::*;
#(
  parameter int    DATA_WIDTH    = 8,
  parameter string DO_MSB_FIRST  = "TRUE",
  parameter string SYNC_REQUIRED = "FALSE"
) (
  input  logic                  clk_i,
  input  logic                  s_rst_n_i,
  input  logic                  enable_i,
  input  logic                  data_i,
  input  logic                  sync_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i,
  output logic                  aligned_o
);

  localparam int                CNT_W         = clog2(DATA_WIDTH);
  localparam bit                MSB_FIRST     = (DO_MSB_FIRST == BIT_ORDER_TRUE);
  localparam bit                HUNT_AT_RESET = (SYNC_REQUIRED == BIT_ORDER_TRUE);
  localparam logic [CNT_W-1:0]  LAST_BIT      = CNT_W'(DATA_WIDTH - 1);

  rx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  m_valid_q, m_valid_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] sr_shifted;
  logic [DATA_WIDTH-1:0] sr_seed;
  logic                  realign;
  logic                  word_done;

  // sr_seed is an empty register with the realigning bit shifted in as bit 0 of a new word.
  assign sr_shifted = MSB_FIRST ? {sr_q[DATA_WIDTH-2:0], data_i}
                                : {data_i, sr_q[DATA_WIDTH-1:1]};
  assign sr_seed    = MSB_FIRST ? {{(DATA_WIDTH-1){1'b0}}, data_i}
                                : {data_i, {(DATA_WIDTH-1){1'b0}}};
  assign realign    = enable_i & sync_i;

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    if (realign) begin
      state_d   = SHIFT;
      sr_d      = sr_seed;
      bit_cnt_d = CNT_W'(1);
    end else if (enable_i && state_q == SHIFT) begin
      sr_d      = sr_shifted;
      word_done = (bit_cnt_q == LAST_BIT);
      bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_comb begin
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    overrun_d = overrun_q;
    if (m_valid_q && m_ready_i) m_valid_d = 1'b0;
    if (overrun_clr_i) overrun_d = 1'b0;
    if (word_done) begin
      if (!m_valid_q || m_ready_i) begin
        m_data_d  = sr_shifted;
        m_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_q   <= HUNT_AT_RESET ? HUNT : SHIFT;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_valid_o = m_valid_q;
  assign overrun_o = overrun_q;
  assign aligned_o = (state_q == SHIFT);

endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: four configurations share one stimulus stream; a word-level model checks every cycle.
module tb_sipo_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, din, sync, rdy, clr;
  logic [7:0]  a_dat, b_dat, c_dat;
  logic [11:0] d_dat;
  logic [3:0]  vld, ovr, aln;
  logic [15:0] act_dat [4];

  assign act_dat[0] = {8'h00, a_dat};
  assign act_dat[1] = {8'h00, b_dat};
  assign act_dat[2] = {8'h00, c_dat};
  assign act_dat[3] = {4'h0, d_dat};

  // u0: MSB first; u1: LSB first; u2: MSB first, sync required; u3: 12-bit MSB first
  sipo_rx #(.DATA_WIDTH(8), .DO_MSB_FIRST("TRUE"), .SYNC_REQUIRED("FALSE")) u0 (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en), .data_i(din), .sync_i(sync),
    .m_data_o(a_dat), .m_valid_o(vld[0]), .m_ready_i(rdy), .overrun_o(ovr[0]),
    .overrun_clr_i(clr), .aligned_o(aln[0]));
  sipo_rx #(.DATA_WIDTH(8), .DO_MSB_FIRST("FALSE"), .SYNC_REQUIRED("FALSE")) u1 (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en), .data_i(din), .sync_i(sync),
    .m_data_o(b_dat), .m_valid_o(vld[1]), .m_ready_i(rdy), .overrun_o(ovr[1]),
    .overrun_clr_i(clr), .aligned_o(aln[1]));
  sipo_rx #(.DATA_WIDTH(8), .DO_MSB_FIRST("TRUE"), .SYNC_REQUIRED("TRUE")) u2 (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en), .data_i(din), .sync_i(sync),
    .m_data_o(c_dat), .m_valid_o(vld[2]), .m_ready_i(rdy), .overrun_o(ovr[2]),
    .overrun_clr_i(clr), .aligned_o(aln[2]));
  sipo_rx #(.DATA_WIDTH(12), .DO_MSB_FIRST("TRUE"), .SYNC_REQUIRED("FALSE")) u3 (
    .clk_i(clk), .s_rst_n_i(rst_n), .enable_i(en), .data_i(din), .sync_i(sync),
    .m_data_o(d_dat), .m_valid_o(vld[3]), .m_ready_i(rdy), .overrun_o(ovr[3]),
    .overrun_clr_i(clr), .aligned_o(aln[3]));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: bits collected since alignment, turned into a word by place value.
  int          W     [4] = '{8, 8, 8, 12};
  bit          MSBF  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit          HUNTR [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  bit          mbits [4][$];
  bit          mal   [4];
  bit          mval  [4];
  logic [15:0] mdat  [4];
  bit          movr  [4];

  task automatic model_step();
    for (int i = 0; i < 4; i++) begin
      bit          comp;
      bit          set_ovr;
      logic [15:0] word;
      comp = 1'b0;
      set_ovr = 1'b0;
      word = '0;
      if (!rst_n) begin
        mbits[i].delete();
        mal[i]  = !HUNTR[i];
        mval[i] = 1'b0;
        mdat[i] = '0;
        movr[i] = 1'b0;
      end else begin
        if (en && sync) begin
          mbits[i].delete();
          mbits[i].push_back(din);
          mal[i] = 1'b1;
        end else if (en && mal[i]) begin
          mbits[i].push_back(din);
          if (mbits[i].size() == W[i]) begin
            for (int k = 0; k < W[i]; k++)
              word = word + (16'(mbits[i][k]) << (MSBF[i] ? W[i] - 1 - k : k));
            comp = 1'b1;
            mbits[i].delete();
          end
        end
        if (comp && mval[i] && !rdy) set_ovr = 1'b1;
        else if (comp) begin
          mdat[i] = word;
          mval[i] = 1'b1;
        end else if (mval[i] && rdy) mval[i] = 1'b0;
        if (clr) movr[i] = 1'b0;
        if (set_ovr) movr[i] = 1'b1;
      end
    end
  endtask

  // One clock: apply inputs, advance model over the edge, compare all outputs just after the edge.
  task automatic cyc(input logic r, input logic e, input logic d, input logic s,
                     input logic rd, input logic c);
    rst_n = r; en = e; din = d; sync = s; rdy = rd; clr = c;
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d_valid", i), 16'(vld[i]), 16'(mval[i]));
      chk($sformatf("u%0d_data", i), act_dat[i], mdat[i]);
      chk($sformatf("u%0d_overrun", i), 16'(ovr[i]), 16'(movr[i]));
      chk($sformatf("u%0d_aligned", i), 16'(aln[i]), 16'(mal[i]));
    end
  endtask

  // Sends n bits of w, most significant first; gap idle cycles between strobes.
  task automatic send_word(input logic [15:0] w, input int n, input bit first_sync,
                           input logic rd, input int gap);
    for (int k = 0; k < n; k++) begin
      if (k > 0) repeat (gap) cyc(1'b1, 1'b0, 1'b0, 1'b0, rd, 1'b0);
      cyc(1'b1, 1'b1, w[n-1-k], first_sync && (k == 0), rd, 1'b0);
    end
  endtask

  typedef struct {
    logic [7:0] seq;
    logic [7:0] exp_msb;
    logic [7:0] exp_lsb;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [7:0] w8;
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5};
    vecs[1] = '{8'h3C, 8'h3C, 8'h3C};
    vecs[2] = '{8'h11, 8'h11, 8'h88};
    vecs[3] = '{8'h01, 8'h01, 8'h80};
    vecs[4] = '{8'hC3, 8'hC3, 8'hC3};
    vecs[5] = '{8'hF0, 8'hF0, 8'h0F};

    // Reset state
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_a_valid", 16'(vld[0]), 16'h0);
    chk("rst_a_data", 16'(a_dat), 16'h0);
    chk("rst_a_overrun", 16'(ovr[0]), 16'h0);
    chk("rst_a_aligned", 16'(aln[0]), 16'h1);
    chk("rst_c_aligned", 16'(aln[2]), 16'h0);

    // Table: each word framed by sync on its first bit, consumer always ready
    for (int v = 0; v < 6; v++) begin
      send_word(16'(vecs[v].seq), 8, 1'b1, 1'b1, 0);
      chk($sformatf("tbl%0d_a_valid", v), 16'(vld[0]), 16'h1);
      chk($sformatf("tbl%0d_a_data", v), 16'(a_dat), 16'(vecs[v].exp_msb));
      chk($sformatf("tbl%0d_b_data", v), 16'(b_dat), 16'(vecs[v].exp_lsb));
      chk($sformatf("tbl%0d_c_data", v), 16'(c_dat), 16'(vecs[v].exp_msb));
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("tbl%0d_a_valid_drop", v), 16'(vld[0]), 16'h0);
    end

    // Stall: second word dropped, first held
    send_word(16'h11, 8, 1'b1, 1'b0, 0);
    send_word(16'h22, 8, 1'b1, 1'b0, 0);
    chk("stall_a_data", 16'(a_dat), 16'h11);
    chk("stall_a_overrun", 16'(ovr[0]), 16'h1);
    chk("stall_b_data", 16'(b_dat), 16'h88);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("stall_consumed_valid", 16'(vld[0]), 16'h0);
    chk("stall_cleared_overrun", 16'(ovr[0]), 16'h0);

    // Overrun set and clear in the same cycle: set wins
    send_word(16'h33, 8, 1'b1, 1'b0, 0);
    w8 = 8'h44;
    for (int k = 0; k < 7; k++) cyc(1'b1, 1'b1, w8[7-k], k == 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, w8[0], 1'b0, 1'b0, 1'b1);
    chk("setwins_overrun", 16'(ovr[0]), 16'h1);
    chk("setwins_data", 16'(a_dat), 16'h33);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Sync hunting: junk ignored, alignment from the sync strobe
    repeat (2) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b1, 1'b1, k[0], 1'b0, 1'b1, 1'b0);
    chk("hunt_c_aligned", 16'(aln[2]), 16'h0);
    chk("hunt_c_valid", 16'(vld[2]), 16'h0);
    w8 = 8'hC3;
    cyc(1'b1, 1'b1, w8[7], 1'b1, 1'b1, 1'b0);
    chk("sync_c_aligned", 16'(aln[2]), 16'h1);
    for (int k = 1; k < 8; k++) cyc(1'b1, 1'b1, w8[7-k], 1'b0, 1'b1, 1'b0);
    chk("sync_c_data", 16'(c_dat), 16'h00C3);
    chk("sync_c_valid", 16'(vld[2]), 16'h1);
    chk("sync_a_data", 16'(a_dat), 16'h00C3);
    // Mid-word realign after 4 bits
    for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 1'b1, k == 0, 1'b1, 1'b0);
    send_word(16'h5A, 8, 1'b1, 1'b1, 0);
    chk("realign_c_data", 16'(c_dat), 16'h005A);
    chk("realign_c_valid", 16'(vld[2]), 16'h1);
    chk("realign_c_overrun", 16'(ovr[2]), 16'h0);

    // Reset mid-word, then a word with no sync
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b1, 1'b1, k == 0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    chk("midrst_a_data", 16'(a_dat), 16'h0);
    chk("midrst_a_valid", 16'(vld[0]), 16'h0);
    chk("midrst_c_aligned", 16'(aln[2]), 16'h0);
    send_word(16'h7E, 8, 1'b0, 1'b1, 0);
    chk("midrst_next_a_data", 16'(a_dat), 16'h007E);
    chk("midrst_next_a_valid", 16'(vld[0]), 16'h1);
    chk("midrst_next_a_overrun", 16'(ovr[0]), 16'h0);
    chk("midrst_next_c_valid", 16'(vld[2]), 16'h0);

    // Gapped strobes, 12-bit word
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_word(16'hABC, 12, 1'b0, 1'b1, 2);
    chk("gap_d_data", 16'(d_dat), 16'h0ABC);
    chk("gap_d_valid", 16'(vld[3]), 16'h1);

    // Random traffic against the model
    for (int n = 0; n < 4000; n++) begin
      cyc(($urandom_range(0, 299) != 0),
          ($urandom_range(0, 9) < 7),
          1'($urandom_range(0, 1)),
          ($urandom_range(0, 39) == 0),
          ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
